// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging three register-file write ports into one write strobe.
// Grants are combinational; the winning write is presented one cycle later with pending tracking.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned IDX_W   = 5,
    localparam int unsigned DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_stall,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]  i_req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_val,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_rf_write,
    output logic [IDX_W-1:0]          o_rf_ctrl_write,
    output logic [DATA_W-1:0]         o_rf_write_val,
    output logic [NUM_REGS-1:0]       o_pending,
    output logic                      o_err
);

    localparam int unsigned GNT_W = $clog2(NUM_REQ);

    logic [GNT_W-1:0]    last_grant_q, last_grant_d;
    logic [GNT_W-1:0]    start_c, idx_c, grant_idx_c;
    logic [NUM_REQ-1:0]  grant_c;
    logic [IDX_W-1:0]    sel_reg_c;
    logic [DATA_W-1:0]   sel_val_c;
    logic                transfer_c, in_range_c;

    logic                rf_write_q, rf_write_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // Rotating-priority grant, starting one past the last winner
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        idx_c       = '0;
        start_c     = (32'(last_grant_q) == NUM_REQ - 1) ? '0 : last_grant_q + 1'b1;
        if (!i_reset && !i_stall) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx_c = GNT_W'((32'(start_c) + k) % NUM_REQ);
                if (grant_c == '0 && i_req_valid[idx_c]) begin
                    grant_c[idx_c] = 1'b1;
                    grant_idx_c    = idx_c;
                end
            end
        end
    end

    // Payload mux for the granted requester
    always_comb begin
        sel_reg_c = '0;
        sel_val_c = '0;
        for (int n = 0; n < int'(NUM_REQ); n++) begin
            if (grant_c[n]) begin
                sel_reg_c = i_req_reg[n*IDX_W +: IDX_W];
                sel_val_c = i_req_val[n*DATA_W +: DATA_W];
            end
        end
    end

    assign transfer_c = |grant_c;
    assign in_range_c = 32'(sel_reg_c) < NUM_REGS;

    // Output stage and pending scoreboard next state; a set beats a same-cycle clear
    always_comb begin
        last_grant_d = last_grant_q;
        rf_write_d   = 1'b0;
        err_d        = 1'b0;
        ctrl_d       = ctrl_q;
        val_d        = val_q;
        pending_d    = pending_q;
        if (rf_write_q) begin
            pending_d = pending_d & ~(NUM_REGS'(1) << ctrl_q);
        end
        if (transfer_c) begin
            last_grant_d = grant_idx_c;
            ctrl_d       = sel_reg_c;
            val_d        = sel_val_c;
            rf_write_d   = in_range_c;
            err_d        = !in_range_c;
            if (in_range_c) begin
                pending_d = pending_d | (NUM_REGS'(1) << sel_reg_c);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant_q <= GNT_W'(NUM_REQ - 1);
            rf_write_q   <= 1'b0;
            err_q        <= 1'b0;
            ctrl_q       <= '0;
            val_q        <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_write_q   <= rf_write_d;
            err_q        <= err_d;
            ctrl_q       <= ctrl_d;
            val_q        <= val_d;
            pending_q    <= pending_d;
        end
    end

    // Reset raised during an output cycle cancels that write before the file captures it
    assign o_req_ready     = grant_c;
    assign o_rf_write      = rf_write_q & ~i_reset;
    assign o_err           = err_q & ~i_reset;
    assign o_rf_ctrl_write = ctrl_q;
    assign o_rf_write_val  = val_q;
    assign o_pending       = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed requests push expected writes,
// a negedge monitor pops and compares whenever a write or error is presented.
module tb_regfile_write_arbiter;

    typedef struct {
        logic        err;
        logic [4:0]  rg;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  valid;
    logic [14:0] req_reg;
    logic [95:0] req_val;
    logic [2:0]  ready;
    logic        rf_write;
    logic [4:0]  rf_ctrl;
    logic [31:0] rf_val;
    logic [15:0] pending;
    logic        err;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] rf_model [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [4:0]  f_reg [3];
    logic [31:0] f_val [3];

    regfile_write_arbiter dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_stall         (stall),
        .i_req_valid     (valid),
        .i_req_reg       (req_reg),
        .i_req_val       (req_val),
        .o_req_ready     (ready),
        .o_rf_write      (rf_write),
        .o_rf_ctrl_write (rf_ctrl),
        .o_rf_write_val  (rf_val),
        .o_pending       (pending),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [4:0] r, input logic [31:0] v);
        req_reg[n*5 +: 5]   = r;
        req_val[n*32 +: 32] = v;
    endtask

    task automatic push(input logic e, input logic [4:0] r, input logic [31:0] v);
        exp_t x;
        x.err = e;
        x.rg  = r;
        x.val = v;
        sb.push_back(x);
    endtask

    // Monitor: every presented write or error must match the oldest expectation
    always @(negedge clk) begin
        if (rf_write || err) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got reg %0d val 0x%0h err %0b, expected no output",
                         rf_ctrl, rf_val, err);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_err", 32'(err), 32'(mon_e.err));
                chk("wr_strobe", 32'(rf_write), 32'(!mon_e.err));
                if (!mon_e.err) begin
                    chk("wr_reg", 32'(rf_ctrl), 32'(mon_e.rg));
                    chk("wr_val", rf_val, mon_e.val);
                end
            end
        end
        if (rf_write) rf_model[rf_ctrl[3:0]] = rf_val;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_model[i] = '0;
        f_reg[0] = 5'd1;  f_reg[1] = 5'd2;  f_reg[2] = 5'd4;
        f_val[0] = 32'hA0; f_val[1] = 32'hA1; f_val[2] = 32'hA2;
        clk = 1'b0; rst = 1'b1; stall = 1'b0; valid = 3'b001;
        req_reg = '0; req_val = '0;

        // Reset values, no grants while in reset even with a request up
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_write", 32'(rf_write), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ctrl", 32'(rf_ctrl), 32'h0);
        chk("rst_val", rf_val, 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);

        // Single request in the first cycle out of reset
        tick();
        rst = 1'b0; valid = 3'b001; set_req(0, 5'd0, 32'h12345678);
        push(1'b0, 5'd0, 32'h12345678);
        @(negedge clk);
        chk("single_ready", 32'(ready), 32'h1);
        chk("single_pend_pre", 32'(pending), 32'h0);
        tick();
        valid = 3'b000;
        @(negedge clk);
        chk("single_ready_idle", 32'(ready), 32'h0);
        chk("single_pend", 32'(pending), 32'h0001);
        chk("single_write", 32'(rf_write), 32'h1);
        tick();
        @(negedge clk);
        chk("single_pend_clr", 32'(pending), 32'h0);
        chk("single_write_off", 32'(rf_write), 32'h0);
        chk("hold_ctrl", 32'(rf_ctrl), 32'h0);
        chk("hold_val", rf_val, 32'h12345678);

        // Fairness from a fresh reset
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid = 3'b111;
        for (int n = 0; n < 3; n++) set_req(n, f_reg[n], f_val[n]);
        for (int k = 0; k < 6; k++) begin
            push(1'b0, f_reg[k % 3], f_val[k % 3]);
            @(negedge clk);
            chk("rr_ready", 32'(ready), 32'(3'b001 << (k % 3)));
            if (k > 0) chk("rr_stream", 32'(rf_write), 32'h1);
            tick();
        end
        valid = 3'b000;
        @(negedge clk);
        chk("rr_last_write", 32'(rf_write), 32'h1);
        chk("rr_ready_idle", 32'(ready), 32'h0);
        tick();
        @(negedge clk);
        chk("rr_done", 32'(rf_write), 32'h0);

        // Same-register conflict with last grant = 0
        tick();
        valid = 3'b001; set_req(0, 5'd5, 32'h55);
        push(1'b0, 5'd5, 32'h55);
        @(negedge clk);
        chk("pre_conf_ready", 32'(ready), 32'h1);
        tick();
        valid = 3'b000;
        @(negedge clk);
        tick();
        valid = 3'b110; set_req(1, 5'd7, 32'hA); set_req(2, 5'd7, 32'hB);
        push(1'b0, 5'd7, 32'hA);
        @(negedge clk);
        chk("conf_ready1", 32'(ready), 32'h2);
        tick();
        valid = 3'b100;
        push(1'b0, 5'd7, 32'hB);
        @(negedge clk);
        chk("conf_ready2", 32'(ready), 32'h4);
        chk("conf_pend_a", 32'(pending[7]), 32'h1);
        tick();
        valid = 3'b000;
        @(negedge clk);
        chk("conf_pend_b", 32'(pending[7]), 32'h1);
        tick();
        @(negedge clk);
        chk("conf_pend_clr", 32'(pending[7]), 32'h0);
        chk("conf_final_r7", rf_model[7], 32'hB);

        // Out-of-range index is granted but only flags an error
        tick();
        valid = 3'b001; set_req(0, 5'd20, 32'hDEAD);
        push(1'b1, 5'd20, 32'hDEAD);
        @(negedge clk);
        chk("oor_ready", 32'(ready), 32'h1);
        tick();
        valid = 3'b000;
        @(negedge clk);
        chk("oor_err", 32'(err), 32'h1);
        chk("oor_write", 32'(rf_write), 32'h0);
        chk("oor_pending", 32'(pending), 32'h0);
        tick();
        @(negedge clk);
        chk("oor_err_pulse", 32'(err), 32'h0);

        // Stall blocks grants but not a write already in its output cycle
        tick();
        valid = 3'b001; set_req(0, 5'd9, 32'h99);
        push(1'b0, 5'd9, 32'h99);
        @(negedge clk);
        chk("stall_pre_ready", 32'(ready), 32'h1);
        tick();
        stall = 1'b1; set_req(0, 5'd10, 32'h1010);
        @(negedge clk);
        chk("stall_ready1", 32'(ready), 32'h0);
        chk("stall_inflight", 32'(rf_write), 32'h1);
        tick();
        @(negedge clk);
        chk("stall_ready2", 32'(ready), 32'h0);
        tick();
        @(negedge clk);
        chk("stall_ready3", 32'(ready), 32'h0);
        tick();
        stall = 1'b0;
        push(1'b0, 5'd10, 32'h1010);
        @(negedge clk);
        chk("stall_release", 32'(ready), 32'h1);
        tick();
        valid = 3'b000;
        @(negedge clk);
        chk("stall_write", 32'(rf_write), 32'h1);
        tick();

        // Reset mid-operation discards the registered write
        valid = 3'b001; set_req(0, 5'd3, 32'h33);
        @(negedge clk);
        chk("mid_ready", 32'(ready), 32'h1);
        tick();
        rst = 1'b1; valid = 3'b000;
        @(negedge clk);
        chk("mid_write_cancel", 32'(rf_write), 32'h0);
        chk("mid_ready_rst", 32'(ready), 32'h0);
        tick();
        rst = 1'b0; valid = 3'b010; set_req(1, 5'd12, 32'hC);
        push(1'b0, 5'd12, 32'hC);
        @(negedge clk);
        chk("mid_write_after", 32'(rf_write), 32'h0);
        chk("mid_pending", 32'(pending), 32'h0);
        chk("mid_ctrl", 32'(rf_ctrl), 32'h0);
        chk("mid_val", rf_val, 32'h0);
        chk("mid_first_grant", 32'(ready), 32'h2);
        chk("mid_r3_untouched", rf_model[3], 32'h0);
        tick();
        valid = 3'b000;
        @(negedge clk);
        tick(); tick();
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
